noc_local_ni: RTL and testbench

Local network interface between a processing core and the router's local port. Injection: segments core messages into 16-bit head/body/tail flits and drives the router local input under credit-based flow control. Ejection: buffers flits from the router local output, hands them to the core, and returns one credit per consumed flit.

---
 rtl/noc_pkg.sv | 45 ++++
 rtl/noc_flit_fifo.sv | 64 ++++++
 rtl/noc_local_ni.sv | 126 ++++++++++++
 tb/tb_noc_local_ni.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types and helpers used by the
// network interface, the router and the bench.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int PAYLOAD_W = 14;
    localparam int TYPE_MSB  = 15;
    localparam int TYPE_LSB  = 14;
    // Destination position inside the HEAD payload
    localparam int DST_MSB   = 13;
    localparam int DST_LSB   = 6;

    typedef enum logic [1:0] {
        FLIT_RSVD = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e             ftype;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } inj_state_e;

    function automatic flit_t make_flit(input flit_type_e ftype, input logic [PAYLOAD_W-1:0] payload);
        flit_t f;
        f.ftype   = ftype;
        f.payload = payload;
        return f;
    endfunction

    function automatic flit_t make_head(input logic [7:0] dst);
        flit_t f;
        f                          = '0;
        f.ftype                    = FLIT_HEAD;
        f.payload[DST_MSB:DST_LSB] = dst;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word fall-through flit FIFO with wrap-around pointers and an
// occupancy count; a push into a full FIFO is taken only alongside a pop.
module noc_flit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == CW'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy update; push and pop may coincide at any fill level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: segments core messages into HEAD/BODY/TAIL flits
// under credit flow control and buffers ejected flits for the core.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int CREDITS  = 4,
    parameter int EJ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [7:0]           tx_dst,
    input  logic [PAYLOAD_W-1:0] tx_data,
    input  logic                 tx_last,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 flit_valid_o,
    input  logic                 credit_i,
    input  logic [FLIT_W-1:0]    flit_i,
    input  logic                 flit_valid_i,
    output logic                 credit_o,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [1:0]           rx_type,
    output logic [PAYLOAD_W-1:0] rx_data,
    output logic                 err_o
);
    localparam int CW = $clog2(CREDITS + 1);

    inj_state_e         state_r;
    logic [CW-1:0]      credits_r;
    logic [CW-1:0]      credits_nxt_s;
    logic               has_credit_s;
    logic               head_req_s;
    logic               word_hs_s;
    logic               send_s;
    logic               ej_pop_s;
    logic               ej_full_s;
    logic               ej_empty_s;
    logic               ej_drop_s;
    logic [FLIT_W-1:0]  ej_rdata_s;

    assign has_credit_s = (credits_r != '0);
    assign tx_ready     = (state_r == ST_BODY) && has_credit_s;
    assign head_req_s   = (state_r == ST_IDLE) && tx_valid && has_credit_s;
    assign word_hs_s    = tx_valid && tx_ready;
    assign send_s       = head_req_s || word_hs_s;

    // Next credit count: a send and a returned credit in the same cycle cancel.
    always_comb begin
        credits_nxt_s = credits_r;
        if (send_s && credit_i) begin
            credits_nxt_s = credits_r;
        end else if (send_s) begin
            credits_nxt_s = credits_r - CW'(1);
        end else if (credit_i && (credits_r != CW'(CREDITS))) begin
            credits_nxt_s = credits_r + CW'(1);
        end else begin
            credits_nxt_s = credits_r;
        end
    end

    // Injection FSM with registered flit outputs and credit count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            credits_r    <= CW'(CREDITS);
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
        end else begin
            credits_r    <= credits_nxt_s;
            flit_valid_o <= send_s;
            case (state_r)
                ST_IDLE: begin
                    if (head_req_s) begin
                        flit_o  <= make_head(tx_dst);
                        state_r <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (word_hs_s) begin
                        flit_o <= make_flit(tx_last ? FLIT_TAIL : FLIT_BODY, tx_data);
                        if (tx_last) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign ej_pop_s  = rx_valid && rx_ready;
    // A push into a full FIFO without a simultaneous pop is lost.
    assign ej_drop_s = flit_valid_i && ej_full_s && !ej_pop_s;

    noc_flit_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (flit_valid_i),
        .pop   (ej_pop_s),
        .wdata (flit_i),
        .rdata (ej_rdata_s),
        .full  (ej_full_s),
        .empty (ej_empty_s)
    );

    assign rx_valid = !ej_empty_s;
    assign rx_type  = ej_empty_s ? 2'b00 : ej_rdata_s[TYPE_MSB:TYPE_LSB];
    assign rx_data  = ej_empty_s ? {PAYLOAD_W{1'b0}} : ej_rdata_s[PAYLOAD_W-1:0];

    // Credit return one cycle after each pop, and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            credit_o <= ej_pop_s;
            err_o    <= err_o | ej_drop_s;
        end
    end

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a scoreboard model.
module tb_noc_local_ni;
    import noc_pkg::*;

    localparam int CREDITS  = 4;
    localparam int EJ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_dst;
    logic [13:0] tx_data;
    logic        tx_last;
    logic [15:0] flit_o;
    logic        flit_valid_o;
    logic        credit_i;
    logic [15:0] flit_i;
    logic        flit_valid_i;
    logic        credit_o;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  rx_type;
    logic [13:0] rx_data;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_local_ni #(.CREDITS(CREDITS), .EJ_DEPTH(EJ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst),
        .tx_data(tx_data), .tx_last(tx_last),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .credit_i(credit_i),
        .flit_i(flit_i), .flit_valid_i(flit_valid_i), .credit_o(credit_o),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_type(rx_type),
        .rx_data(rx_data), .err_o(err_o)
    );

    typedef struct packed {
        logic        tx_valid;
        logic [13:0] data;
        logic        last;
        logic        credit;
        logic        exp_fv;
        logic [15:0] exp_flit;
        logic        exp_ready;
    } inj_vec_t;

    inj_vec_t    vecs [23];
    logic [15:0] ej_vals [5];

    // random-phase model state
    logic [14:0] word_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] ej_q [$];
    int          credits_m;
    int          sent_tot;
    int          ret_tot;
    bit          msg_open;
    bit          err_m;
    logic [7:0]  cur_dst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        tx_valid     = 1'b0;
        tx_dst       = 8'h00;
        tx_data      = 14'h0000;
        tx_last      = 1'b0;
        credit_i     = 1'b0;
        flit_i       = 16'h0000;
        flit_valid_i = 1'b0;
        rx_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, 14'h001, 1'b0, 1'b0, 1'b1, 16'h4840, 1'b1};
        vecs[1]  = '{1'b1, 14'h001, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1};
        vecs[2]  = '{1'b1, 14'h002, 1'b0, 1'b0, 1'b1, 16'h8002, 1'b1};
        vecs[3]  = '{1'b1, 14'h003, 1'b1, 1'b0, 1'b1, 16'hC003, 1'b0};
        for (int i = 4; i < 8; i++) vecs[i] = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 14'h010, 1'b0, 1'b0, 1'b1, 16'h4840, 1'b1};
        vecs[9]  = '{1'b1, 14'h010, 1'b0, 1'b0, 1'b1, 16'h8010, 1'b1};
        vecs[10] = '{1'b1, 14'h011, 1'b0, 1'b0, 1'b1, 16'h8011, 1'b1};
        vecs[11] = '{1'b1, 14'h012, 1'b0, 1'b0, 1'b1, 16'h8012, 1'b0};
        vecs[12] = '{1'b1, 14'h013, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[13] = '{1'b1, 14'h013, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[14] = '{1'b1, 14'h013, 1'b0, 1'b0, 1'b1, 16'h8013, 1'b0};
        vecs[15] = '{1'b1, 14'h014, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[16] = '{1'b1, 14'h014, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[17] = '{1'b1, 14'h014, 1'b0, 1'b1, 1'b1, 16'h8014, 1'b1};
        vecs[18] = '{1'b1, 14'h015, 1'b1, 1'b0, 1'b1, 16'hC015, 1'b0};
        for (int i = 19; i < 23; i++) vecs[i] = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        ej_vals = '{16'h4123, 16'h8456, 16'h8789, 16'hC0AB, 16'h8CDE};

        // reset state
        do_reset();
        check("rst_flit_o", 32'(flit_o), 32'h0);
        check("rst_flit_valid", 32'(flit_valid_o), 32'h0);
        check("rst_credit_o", 32'(credit_o), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);

        // table: 3-word message, credit exhaustion and single-credit release
        tx_dst = 8'h21;
        for (int i = 0; i < 23; i++) begin
            tx_valid = vecs[i].tx_valid;
            tx_data  = vecs[i].data;
            tx_last  = vecs[i].last;
            credit_i = vecs[i].credit;
            tick();
            check($sformatf("vec%0d_flit_valid", i), 32'(flit_valid_o), 32'(vecs[i].exp_fv));
            check($sformatf("vec%0d_tx_ready", i), 32'(tx_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_fv) check($sformatf("vec%0d_flit", i), 32'(flit_o), 32'(vecs[i].exp_flit));
        end

        // 10-word stream with a credit returned every cycle: no stall
        tx_valid = 1'b1; tx_data = 14'h020; tx_last = 1'b0; credit_i = 1'b1;
        tick();
        check("stream_head", 32'(flit_o), 32'h4840);
        for (int i = 0; i < 10; i++) begin
            logic [13:0] d;
            d = 14'h020 + 14'(i);
            check("stream_ready", 32'(tx_ready), 32'h1);
            tx_data = d;
            tx_last = (i == 9);
            tick();
            check("stream_valid", 32'(flit_valid_o), 32'h1);
            check("stream_flit", 32'(flit_o), 32'({(i == 9) ? 2'b11 : 2'b10, d}));
        end
        tx_valid = 1'b0; tx_last = 1'b0; credit_i = 1'b0;
        tick();
        check("stream_end_valid", 32'(flit_valid_o), 32'h0);

        // spurious credits at full count must saturate: still only 4 sends
        credit_i = 1'b1;
        tick();
        tick();
        credit_i = 1'b0;
        tx_valid = 1'b1; tx_data = 14'h0AA;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n += int'(flit_valid_o);
        end
        check("sat_flit_count", 32'(n), 32'd4);
        check("sat_tx_ready", 32'(tx_ready), 32'h0);

        // ejection: fill, full push+pop, ordered drain with credit pulses
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flit_valid_i = 1'b1; flit_i = ej_vals[i];
            tick();
            check("ej_fill_valid", 32'(rx_valid), 32'h1);
            check("ej_fill_credit", 32'(credit_o), 32'h0);
        end
        check("ej_head_type", 32'(rx_type), 32'h1);
        check("ej_head_data", 32'(rx_data), 32'h0123);
        flit_i = ej_vals[4]; rx_ready = 1'b1;
        tick();
        check("ej_fullpp_err", 32'(err_o), 32'h0);
        check("ej_fullpp_credit", 32'(credit_o), 32'h1);
        flit_valid_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check("ej_order", 32'({rx_type, rx_data}), 32'(ej_vals[i]));
            tick();
            check("ej_credit_pulse", 32'(credit_o), 32'h1);
        end
        check("ej_drained", 32'(rx_valid), 32'h0);
        rx_ready = 1'b0;
        tick();
        check("ej_credit_idle", 32'(credit_o), 32'h0);

        // overflow: push into full FIFO without pop is dropped, err sticky
        for (int i = 0; i < 4; i++) begin
            flit_valid_i = 1'b1; flit_i = ej_vals[i];
            tick();
        end
        flit_i = 16'hFFFF;
        tick();
        check("ovf_err", 32'(err_o), 32'h1);
        check("ovf_head", 32'({rx_type, rx_data}), 32'(ej_vals[0]));
        flit_valid_i = 1'b0;
        tick();
        tick();
        check("ovf_sticky", 32'(err_o), 32'h1);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_order", 32'({rx_type, rx_data}), 32'(ej_vals[i]));
            tick();
        end
        check("ovf_dropped", 32'(rx_valid), 32'h0);
        check("ovf_err_hold", 32'(err_o), 32'h1);
        rx_ready = 1'b0;

        // reset mid-message with a flit in flight and FIFO occupied
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0; flit_valid_i = 1'b1; flit_i = ej_vals[1];
        tick();
        check("pre_rst_flit_valid", 32'(flit_valid_o), 32'h1);
        check("pre_rst_rx_valid", 32'(rx_valid), 32'h1);
        flit_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_flit_valid", 32'(flit_valid_o), 32'h0);
        check("mid_rst_flit_o", 32'(flit_o), 32'h0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_err", 32'(err_o), 32'h0);
        tick();
        rst = 1'b1;
        tx_dst = 8'h35; tx_valid = 1'b1; tx_last = 1'b0; tx_data = 14'h001;
        tick();
        check("post_rst_head_valid", 32'(flit_valid_o), 32'h1);
        check("post_rst_head", 32'(flit_o), 32'h4D40);
        n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(flit_valid_o);
        end
        check("post_rst_credits", 32'(n), 32'd4);
        check("post_rst_fifo_empty", 32'(rx_valid), 32'h0);

        // randomized run against the scoreboard model
        do_reset();
        credits_m = CREDITS; sent_tot = 0; ret_tot = 0;
        msg_open = 1'b0; err_m = 1'b0; cur_dst = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        exp_send;
            logic        hs;
            logic        pop;
            logic        push_ok;
            logic [15:0] f;
            if (word_q.size() == 0 && !msg_open && $urandom_range(0, 3) == 0) begin
                int          len;
                logic [13:0] d;
                len     = int'($urandom_range(1, 6));
                cur_dst = 8'($urandom);
                exp_q.push_back({2'b01, cur_dst, 6'b000000});
                for (int k = 0; k < len; k++) begin
                    d = 14'($urandom);
                    word_q.push_back({(k == len - 1), d});
                    exp_q.push_back({(k == len - 1) ? 2'b11 : 2'b10, d});
                end
            end
            tx_dst = cur_dst;
            if (word_q.size() > 0) begin
                tx_valid = ($urandom_range(0, 3) != 0);
                {tx_last, tx_data} = word_q[0];
            end else begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                tx_data  = 14'($urandom);
            end
            credit_i     = (sent_tot > ret_tot) && ($urandom_range(0, 1) == 1);
            flit_valid_i = ($urandom_range(0, 1) == 1);
            flit_i       = 16'($urandom);
            rx_ready     = ($urandom_range(0, 2) != 0);

            check("rnd_tx_ready", 32'(tx_ready), 32'(msg_open && credits_m > 0));
            check("rnd_rx_valid", 32'(rx_valid), 32'(ej_q.size() > 0));
            if (ej_q.size() > 0) check("rnd_rx_head", 32'({rx_type, rx_data}), 32'(ej_q[0]));
            check("rnd_err", 32'(err_o), 32'(err_m));

            exp_send = tx_valid && credits_m > 0;
            hs       = tx_valid && msg_open && credits_m > 0;
            pop      = (ej_q.size() > 0) && rx_ready;
            push_ok  = flit_valid_i && (ej_q.size() < EJ_DEPTH || pop);
            tick();

            check("rnd_flit_valid", 32'(flit_valid_o), 32'(exp_send));
            if (exp_send) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_scoreboard: flit %0h sent, none expected", flit_o);
                end else begin
                    f = exp_q.pop_front();
                    check("rnd_flit", 32'(flit_o), 32'(f));
                    if (f[15:14] == 2'b01) msg_open = 1'b1;
                    else if (f[15:14] == 2'b11) msg_open = 1'b0;
                end
                sent_tot++;
            end
            if (hs) void'(word_q.pop_front());
            credits_m = credits_m - (exp_send ? 1 : 0) + (credit_i ? 1 : 0);
            if (credit_i) ret_tot++;
            check("rnd_credit_o", 32'(credit_o), 32'(pop));
            if (pop) void'(ej_q.pop_front());
            if (push_ok) ej_q.push_back(flit_i);
            if (flit_valid_i && !push_ok) err_m = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
